rom_stream_reader: RTL and testbench

Read-side master for the team's synchronous 32x8 `rom`. On a start pulse it walks a contiguous address range, drives the ROM's `en`/`addr` port, accounts for the ROM's one-cycle read latency, and delivers each byte on a valid/ready stream. A 2-entry output buffer with credit-based issue keeps full throughput and never drops a word under consumer backpressure.

---
 rtl/rom_stream_reader.sv | 129 ++++++++++++
 tb/tb_rom_stream_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Read-side master for a synchronous 1-cycle-latency ROM: walks an address range
// and streams the bytes out through a 2-entry valid/ready buffer with credit-based issue.
module rom_stream_reader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [1:0]        occ_q, occ_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];

  logic pop;
  logic issue;

  // Credit check: buffered + in-flight words, net of this cycle's pop, must leave a free slot.
  assign pop   = (occ_q != 2'd0) & out_ready;
  assign issue = (state_q == S_RUN) && (remain_q != '0) &&
                 (3'({1'b0, occ_q}) + 3'(inflight_q) < 3'd2 + 3'(pop));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    rom_addr_d = rom_addr_q;
    done_d     = 1'b0;
    inflight_d = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    mem_d      = mem_q;
    occ_d      = 2'(occ_q + 2'(inflight_q) - 2'(pop));

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          if (count != '0) begin
            addr_d   = start_addr;
            remain_d = count;
            state_d  = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          rom_addr_d = addr_q;
          addr_d     = ADDR_W'(addr_q + 1'b1);
          remain_d   = CNT_W'(remain_q - 1'b1);
          if (remain_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_q == 2'd1 && !inflight_q && pop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Returning ROM word lands at the tail; the issue rule guarantees a free slot.
    if (inflight_q) begin
      mem_d[tail_q] = rom_data;
      tail_d        = ~tail_q;
    end
    if (pop) head_d = ~head_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      rom_addr_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      rom_addr_q <= rom_addr_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      mem_q      <= mem_d;
    end
  end

  assign rom_en    = issue;
  assign rom_addr  = issue ? addr_q : rom_addr_q;
  assign out_data  = mem_q[head_q];
  assign out_valid = (occ_q != 2'd0);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a behavioural 32x8 ROM that returns X
// whenever no read is in flight.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] start_addr;
  logic [5:0] count;
  logic       rom_en;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom_tb [32];

  int         got [64];
  int         got_n;
  int         en_addr [64];
  int         en_n;
  logic       en_hist [256];
  logic       valid_hist [256];
  logic [7:0] data_hist [256];
  int         done_cyc;
  int         both_err;
  int         occ_err;
  int         max_occ;
  int         en_before10;

  always #5 clk = ~clk;

  rom_stream_reader #(.ADDR_W(5), .DATA_W(8), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always @(posedge clk) rom_data <= rom_en ? rom_tb[rom_addr] : 8'hxx;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int cyc, input int low_until);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc > low_until);
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one burst; cycle 1 is the cycle after the edge that samples start.
  task automatic run_burst(input logic [4:0] sa, input logic [5:0] cnt, input int mode,
                           input int low_until, input int inject_cyc);
    int   cyc;
    int   occ_m;
    logic infl_m;
    logic pop;
    got_n = 0; en_n = 0; done_cyc = -1; both_err = 0; occ_err = 0; max_occ = 0;
    en_before10 = 0;
    for (int i = 0; i < 256; i++) begin
      en_hist[i] = 1'b0; valid_hist[i] = 1'b0; data_hist[i] = 8'h00;
    end
    out_ready = ready_for(mode, 0, low_until);
    step;
    start_addr = sa; count = cnt; start = 1'b1;
    step;
    start = 1'b0;
    cyc = 1; occ_m = 0; infl_m = 1'b0;
    while (cyc < 200) begin
      if (cyc == inject_cyc) begin
        start = 1'b1; start_addr = 5'd20; count = 6'd3;
      end else begin
        start = 1'b0;
      end
      out_ready = ready_for(mode, cyc, low_until);
      #1;
      en_hist[cyc] = rom_en; valid_hist[cyc] = out_valid; data_hist[cyc] = out_data;
      if (rom_en) begin
        en_addr[en_n] = int'(rom_addr); en_n++;
        if (cyc < 10) en_before10++;
      end
      pop = out_valid & out_ready;
      if (pop) begin
        got[got_n] = int'(out_data); got_n++;
      end
      if (out_valid !== (occ_m != 0)) occ_err++;
      if (busy && done) both_err++;
      occ_m = occ_m + int'(infl_m) - int'(pop);
      if (occ_m > max_occ) max_occ = occ_m;
      infl_m = rom_en;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      step;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b0;
    step; step;
    checks++;
    if ({rom_en, rom_addr, out_valid, out_data, busy, done} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%0b addr=%0d valid=%0b data=%0d busy=%0b done=%0b, want all 0",
               rom_en, rom_addr, out_valid, out_data, busy, done);
    end
    rst = 1'b0;
    step;
  endtask

  task automatic test_basic;
    int exp [4] = '{4, 3, 9, 10};
    run_burst(5'd0, 6'd4, 0, 0, -1);
    checks++;
    if (got_n !== 4) begin errors++; $display("FAIL basic_count: got %0d words, want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("FAIL basic_word%0d: got %0d, want %0d", i, got[i], exp[i]);
      end
    end
    checks++;
    if (done_cyc !== 7) begin errors++; $display("FAIL basic_done_cycle: got %0d, want 7", done_cyc); end
    checks++;
    if ({en_hist[1], en_hist[2], en_hist[3], en_hist[4], en_hist[5], en_hist[6]} !== 6'b111100) begin
      errors++; $display("FAIL basic_rom_en_cycles: got %b, want 111100",
                         {en_hist[1], en_hist[2], en_hist[3], en_hist[4], en_hist[5], en_hist[6]});
    end
    checks++;
    if ({valid_hist[2], valid_hist[3]} !== 2'b01) begin
      errors++; $display("FAIL basic_first_valid: got %b, want 01", {valid_hist[2], valid_hist[3]});
    end
    checks++;
    if (both_err !== 0 || occ_err !== 0) begin
      errors++; $display("FAIL basic_flags: got both=%0d occ=%0d, want 0 0", both_err, occ_err);
    end
  endtask

  task automatic test_wrap;
    int exp [4] = '{44, 46, 4, 3};
    int ea  [4] = '{30, 31, 0, 1};
    run_burst(5'd30, 6'd4, 0, 0, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("FAIL wrap_word%0d: got %0d, want %0d", i, got[i], exp[i]);
      end
      checks++;
      if (en_addr[i] !== ea[i]) begin
        errors++; $display("FAIL wrap_addr%0d: got %0d, want %0d", i, en_addr[i], ea[i]);
      end
    end
    checks++;
    if (en_n !== 4 || got_n !== 4) begin
      errors++; $display("FAIL wrap_counts: got en=%0d words=%0d, want 4 4", en_n, got_n);
    end
  endtask

  task automatic test_backpressure;
    int exp [6] = '{33, 5, 45, 18, 7, 17};
    int held_bad;
    run_burst(5'd8, 6'd6, 1, 9, -1);
    checks++;
    if (en_before10 !== 2) begin
      errors++; $display("FAIL bp_rom_en_pulses: got %0d, want 2", en_before10);
    end
    held_bad = 0;
    for (int c = 3; c <= 9; c++) if (!valid_hist[c] || data_hist[c] !== 8'd33) held_bad++;
    checks++;
    if (held_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles, want 0", held_bad); end
    checks++;
    if (got_n !== 6 || done_cyc < 0) begin
      errors++; $display("FAIL bp_complete: got words=%0d done_cyc=%0d, want 6 and done", got_n, done_cyc);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("FAIL bp_word%0d: got %0d, want %0d", i, got[i], exp[i]);
      end
    end
    checks++;
    if (max_occ > 2 || occ_err !== 0) begin
      errors++; $display("FAIL bp_occ: got max=%0d err=%0d, want <=2 and 0", max_occ, occ_err);
    end
  endtask

  task automatic test_random;
    int bad;
    run_burst(5'd0, 6'd32, 2, 0, -1);
    checks++;
    if (got_n !== 32 || done_cyc < 0) begin
      errors++; $display("FAIL rand_count: got %0d words done_cyc=%0d, want 32 and done", got_n, done_cyc);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (got[i] !== int'(rom_tb[i])) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rand_order: got %0d wrong words, want 0", bad); end
    checks++;
    if (max_occ > 2 || occ_err !== 0 || both_err !== 0) begin
      errors++; $display("FAIL rand_occ: got max=%0d err=%0d both=%0d, want <=2 0 0",
                         max_occ, occ_err, both_err);
    end
  endtask

  task automatic test_count_zero;
    int anyv;
    run_burst(5'd5, 6'd0, 0, 0, -1);
    checks++;
    if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d, want 1", done_cyc); end
    anyv = 0;
    for (int c = 1; c < 4; c++) if (valid_hist[c]) anyv++;
    checks++;
    if (en_n !== 0 || anyv !== 0 || both_err !== 0) begin
      errors++; $display("FAIL zero_quiet: got en=%0d valid=%0d both=%0d, want 0 0 0", en_n, anyv, both_err);
    end
  endtask

  task automatic test_busy_start;
    int exp [4] = '{4, 3, 9, 10};
    run_burst(5'd0, 6'd4, 0, 0, 3);
    checks++;
    if (got_n !== 4 || done_cyc !== 7 || en_n !== 4) begin
      errors++; $display("FAIL busy_start_shape: got words=%0d done=%0d en=%0d, want 4 7 4",
                         got_n, done_cyc, en_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp[i] || en_addr[i] !== i) begin
        errors++; $display("FAIL busy_start_word%0d: got %0d@%0d, want %0d@%0d",
                           i, got[i], en_addr[i], exp[i], i);
      end
    end
  endtask

  task automatic test_mid_reset;
    step;
    start_addr = 5'd0; count = 6'd10; start = 1'b1; out_ready = 1'b0;
    step;
    start = 1'b0;
    step; step; step;
    rst = 1'b1;
    step;
    checks++;
    if ({rom_en, rom_addr, out_valid, out_data, busy, done} !== 17'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got en=%0b addr=%0d valid=%0b data=%0d busy=%0b done=%0b, want all 0",
               rom_en, rom_addr, out_valid, out_data, busy, done);
    end
    rst = 1'b0;
    run_burst(5'd2, 6'd1, 0, 0, -1);
    checks++;
    if (got_n !== 1 || got[0] !== 9 || done_cyc !== 4) begin
      errors++; $display("FAIL midrst_restart: got words=%0d first=%0d done=%0d, want 1 9 4",
                         got_n, got[0], done_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_tb[i] = 8'((i * 7 + 11) & 8'hff);
    rom_tb[0] = 8'd4;   rom_tb[1] = 8'd3;   rom_tb[2] = 8'd9;   rom_tb[3] = 8'd10;
    rom_tb[8] = 8'd33;  rom_tb[9] = 8'd5;   rom_tb[10] = 8'd45; rom_tb[11] = 8'd18;
    rom_tb[12] = 8'd7;  rom_tb[13] = 8'd17; rom_tb[30] = 8'd44; rom_tb[31] = 8'd46;
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_random;
    test_count_zero;
    test_busy_start;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
